// File: rtl/riscv_pkg.sv
// Shared encodings for the LSU memory stage: access sizes, writeback select,
// FSM states and store lane helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  // funct3[1:0] carries the size; funct3[2] only selects zero-extension.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh;
  logic        sext;

  always_comb begin
    sh   = rdata >> {off, 3'b000};
    sext = ~funct3[2];
    case (funct3[1:0])
      2'b00:   data = {{24{sext & sh[7]}}, sh[7:0]};
      2'b01:   data = {{16{sext & sh[15]}}, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage: issues one data-memory transaction per load/store, stalls the
// front of the pipe until ack, and aborts with a bus error on watchdog expiry.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] pc4_i,
  input  logic [4:0]  RegDst_i,
  input  logic        RegWEn_i,
  input  logic [1:0]  WBSel_i,
  output logic [4:0]  RegDst_o,
  output logic        RegWEn_o,
  output logic [31:0] data_wb_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        buserr_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  lsu_state_e     state;
  logic [WDW-1:0] wdog;
  logic [31:0]    ld_data;
  logic [2:0]     f3_q;
  logic [1:0]     off_q;
  logic [31:0]    ld_aligned;

  logic memop, mis, start, timeout;

  lsu_load_align u_align (
    .rdata  (dmem_rdata_i),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ld_aligned)
  );

  // mis is qualified by memop so ALU ops with odd results are never bubbled.
  always_comb begin
    memop      = valid_i & (MemRd_i | MemWr_i);
    mis        = memop & is_misaligned(funct3_i, alu_res_i[1:0]);
    start      = (state == S_IDLE) & memop & ~mis & ~buserr_o;
    timeout    = (state == S_BUSY) & ~dmem_ack_i & (wdog == WD_LAST);
    stall_o    = start | (state == S_BUSY);
    misalign_o = ~rst & (state == S_IDLE) & mis;
    RegDst_o   = RegDst_i;
    RegWEn_o   = RegWEn_i & valid_i & ~stall_o & ~mis & ~buserr_o;
    case (WBSel_i)
      WB_ALU:  data_wb_o = alu_res_i;
      WB_MEM:  data_wb_o = ld_data;
      WB_PC4:  data_wb_o = pc4_i;
      default: data_wb_o = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wdog         <= '0;
      ld_data      <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      buserr_o     <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else begin
      buserr_o <= timeout;
      case (state)
        S_IDLE: if (start) begin
          state        <= S_BUSY;
          wdog         <= '0;
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= MemWr_i;
          dmem_addr_o  <= {alu_res_i[31:2], 2'b00};
          dmem_be_o    <= store_be(funct3_i, alu_res_i[1:0]);
          dmem_wdata_o <= store_wdata(funct3_i, rs2_data_i);
          f3_q         <= funct3_i;
          off_q        <= alu_res_i[1:0];
        end
        S_BUSY: begin
          if (dmem_ack_i) begin
            state      <= S_DONE;
            dmem_req_o <= 1'b0;
            if (!dmem_we_o) ld_data <= ld_aligned;
          end else if (timeout) begin
            state      <= S_IDLE;
            dmem_req_o <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a behavioural model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, MemRd_i, MemWr_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, rs2_data_i, pc4_i;
  logic [4:0]  RegDst_i;
  logic        RegWEn_i;
  logic [1:0]  WBSel_i;
  logic [4:0]  RegDst_o;
  logic        RegWEn_o;
  logic [31:0] data_wb_o;
  logic        stall_o, misalign_o, buserr_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_ld;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .MemRd_i(MemRd_i), .MemWr_i(MemWr_i),
    .funct3_i(funct3_i), .alu_res_i(alu_res_i), .rs2_data_i(rs2_data_i), .pc4_i(pc4_i),
    .RegDst_i(RegDst_i), .RegWEn_i(RegWEn_i), .WBSel_i(WBSel_i),
    .RegDst_o(RegDst_o), .RegWEn_o(RegWEn_o), .data_wb_o(data_wb_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .buserr_o(buserr_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
  );

  // Reference model: byte lanes computed by shifting and masking.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a[1:0]);
    case (f3[1:0])
      2'd0: begin v = v & 32'hFF;   if (!f3[2] && v >= 128)   v = v - 256;   end
      2'd1: begin v = v & 32'hFFFF; if (!f3[2] && v >= 32768) v = v - 65536; end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    m = (f3[1:0] == 2'd0) ? 4'h1 : (f3[1:0] == 2'd1) ? 4'h3 : 4'hF;
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return {24'h0, d[7:0]} * 32'h01010101;
    if (f3[1:0] == 2'd1) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  task automatic idle_inputs();
    valid_i = 0; MemRd_i = 0; MemWr_i = 0; funct3_i = 0; alu_res_i = 0;
    rs2_data_i = 0; pc4_i = 0; RegDst_i = 0; RegWEn_i = 0; WBSel_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic present(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [4:0] rd, input bit rwe);
    valid_i = 1; MemRd_i = !st; MemWr_i = st; funct3_i = f3; alu_res_i = a;
    rs2_data_i = rs2; RegDst_i = rd; RegWEn_i = rwe; WBSel_i = st ? 2'b00 : 2'b01;
    pc4_i = $urandom; dmem_ack_i = 0;
  endtask

  // One aligned load/store with ack after lat extra cycles.
  task automatic mem_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [31:0] rdat, input int lat,
                        input string nm);
    logic [4:0] rd = 5'($urandom);
    logic [31:0] ew;
    present(st, f3, a, rs2, rd, 1'b1);
    @(negedge clk);
    tests++;
    if ({stall_o, dmem_req_o, misalign_o, RegWEn_o} !== 4'b1000) begin
      fails++;
      $display("FAIL %s issue: stall/req/mis/wen=%b exp 1000", nm,
               {stall_o, dmem_req_o, misalign_o, RegWEn_o});
    end
    for (int k = 0; k <= lat; k++) begin
      next();
      dmem_ack_i = (k == lat);
      dmem_rdata_i = (k == lat) ? rdat : $urandom;
      @(negedge clk);
      tests++;
      if ({dmem_req_o, dmem_we_o, dmem_addr_o, stall_o} !== {1'b1, st, a & 32'hFFFFFFFC, 1'b1}) begin
        fails++;
        $display("FAIL %s busy%0d: req=%b we=%b addr=%h stall=%b exp addr %h we %b",
                 nm, k, dmem_req_o, dmem_we_o, dmem_addr_o, stall_o, a & 32'hFFFFFFFC, st);
      end
      if (st) begin
        tests++;
        if ({dmem_be_o, dmem_wdata_o} !== {exp_be(f3, a), exp_wd(f3, rs2)}) begin
          fails++;
          $display("FAIL %s store lanes: be=%b wdata=%h exp be=%b wdata=%h", nm,
                   dmem_be_o, dmem_wdata_o, exp_be(f3, a), exp_wd(f3, rs2));
        end
      end
    end
    next();
    dmem_ack_i = 0;
    if (!st) last_ld = exp_load(f3, a, rdat);
    ew = st ? a : last_ld;
    @(negedge clk);
    tests++;
    if ({stall_o, dmem_req_o, RegWEn_o, RegDst_o, data_wb_o} !== {1'b0, 1'b0, 1'b1, rd, ew}) begin
      fails++;
      $display("FAIL %s done: stall=%b req=%b wen=%b rd=%0d wb=%h exp wb=%h rd=%0d",
               nm, stall_o, dmem_req_o, RegWEn_o, RegDst_o, data_wb_o, ew, rd);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) next();
    rst = 0;
    WBSel_i = 2'b01;
    last_ld = 0;
    @(negedge clk);
    tests++;
    if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, misalign_o,
         buserr_o, stall_o, data_wb_o} !== '0) begin
      fails++;
      $display("FAIL reset: req=%b we=%b be=%b addr=%h wd=%h mis=%b berr=%b stall=%b wb=%h",
               dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o, misalign_o,
               buserr_o, stall_o, data_wb_o);
    end
    next();
  endtask

  task automatic test_vectors();
    mem_op(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw_0x100");
    mem_op(0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, "lb_0x103");
    mem_op(0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, "lbu_0x103");
    mem_op(1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, "sh_0x202");
  endtask

  task automatic test_misalign();
    logic [2:0] f3s [3] = '{3'b010, 3'b001, 3'b101};
    for (int i = 0; i < 6; i++) begin
      logic [2:0] f3 = f3s[i % 3];
      logic [31:0] a = $urandom;
      if (i == 0) a = 32'h101;
      else if (f3[1:0] == 2'd1) a[0] = 1'b1;
      else if (a[1:0] == 2'd0) a[1:0] = 2'd3;
      present(i[0], f3, a, $urandom, 5'd7, 1'b1);
      @(negedge clk);
      tests++;
      if ({misalign_o, dmem_req_o, stall_o, RegWEn_o} !== 4'b1000) begin
        fails++;
        $display("FAIL misalign%0d a=%h: mis/req/stall/wen=%b exp 1000", i, a,
                 {misalign_o, dmem_req_o, stall_o, RegWEn_o});
      end
      next();
      idle_inputs();
      @(negedge clk);
      tests++;
      if ({misalign_o, dmem_req_o} !== 2'b00) begin
        fails++;
        $display("FAIL misalign%0d after: mis/req=%b exp 00", i, {misalign_o, dmem_req_o});
      end
      next();
    end
  endtask

  task automatic test_random();
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      bit st = $urandom_range(0, 1);
      logic [2:0] f3 = st ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
      logic [31:0] a = $urandom;
      if (f3[1:0] == 2'd1) a[0] = 1'b0;
      if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
      mem_op(st, f3, a, $urandom, $urandom, $urandom_range(0, 4), "random");
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ew;
      valid_i = $urandom_range(0, 1); MemRd_i = 0; MemWr_i = 0;
      funct3_i = 3'($urandom); alu_res_i = $urandom; pc4_i = $urandom;
      RegDst_i = 5'($urandom); RegWEn_i = 1; WBSel_i = 2'(i % 4);
      case (WBSel_i)
        2'd0: ew = alu_res_i;
        2'd1: ew = last_ld;
        2'd2: ew = pc4_i;
        default: ew = 0;
      endcase
      @(negedge clk);
      tests++;
      if ({stall_o, dmem_req_o, misalign_o, RegWEn_o, RegDst_o, data_wb_o} !==
          {3'b000, valid_i, RegDst_i, ew}) begin
        fails++;
        $display("FAIL pass%0d: stall=%b req=%b mis=%b wen=%b rd=%0d wb=%h exp wb=%h",
                 i, stall_o, dmem_req_o, misalign_o, RegWEn_o, RegDst_o, data_wb_o, ew);
      end
      next();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    present(0, 3'b010, 32'h340, 32'h0, 5'd3, 1'b1);
    for (int k = 0; k < 16; k++) begin
      next();
      @(negedge clk);
      tests++;
      if ({dmem_req_o, stall_o, buserr_o} !== 3'b110) begin
        fails++;
        $display("FAIL timeout wait%0d: req/stall/berr=%b exp 110", k,
                 {dmem_req_o, stall_o, buserr_o});
      end
    end
    next();
    @(negedge clk);
    tests++;
    if ({buserr_o, dmem_req_o, stall_o, RegWEn_o} !== 4'b1000) begin
      fails++;
      $display("FAIL timeout abort: berr/req/stall/wen=%b exp 1000",
               {buserr_o, dmem_req_o, stall_o, RegWEn_o});
    end
    next();
    idle_inputs();
    dmem_ack_i = 1; dmem_rdata_i = 32'hCAFEF00D; WBSel_i = 2'b01;
    @(negedge clk);
    tests++;
    if ({buserr_o, dmem_req_o, stall_o} !== 3'b000) begin
      fails++;
      $display("FAIL timeout after: berr/req/stall=%b exp 000", {buserr_o, dmem_req_o, stall_o});
    end
    next();
    dmem_ack_i = 0;
    @(negedge clk);
    tests++;
    if ({dmem_req_o, data_wb_o} !== {1'b0, last_ld}) begin
      fails++;
      $display("FAIL late ack: req=%b wb=%h exp wb=%h", dmem_req_o, data_wb_o, last_ld);
    end
    next();
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    present(0, 3'b010, 32'h480, 32'h0, 5'd9, 1'b1);
    next();
    @(negedge clk);
    tests++;
    if (dmem_req_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_busy req: got %b exp 1", dmem_req_o);
    end
    rst = 1;
    next();
    rst = 0;
    idle_inputs();
    dmem_ack_i = 1; dmem_rdata_i = 32'h12345678; RegWEn_i = 1; WBSel_i = 2'b01;
    last_ld = 0;
    @(negedge clk);
    tests++;
    if ({dmem_req_o, stall_o, RegWEn_o} !== 3'b000) begin
      fails++;
      $display("FAIL rst_busy ack: req/stall/wen=%b exp 000", {dmem_req_o, stall_o, RegWEn_o});
    end
    next();
    dmem_ack_i = 0;
    @(negedge clk);
    tests++;
    if ({dmem_req_o, data_wb_o} !== {1'b0, 32'h0}) begin
      fails++;
      $display("FAIL rst_busy wb: req=%b wb=%h exp 0", dmem_req_o, data_wb_o);
    end
    next();
    mem_op(0, 3'b001, 32'h486, 32'h0, 32'h9ABC1234, 2, "lh_after_rst");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_misalign();
    test_random();
    test_passthrough();
    test_timeout();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
